// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller: synchronised request lines, edge/level latching,
// fixed priority with nesting, vector address generation and a byte-wide register window.
module interrupt_controller #(
    parameter int unsigned NUM_SRC     = 8,
    parameter logic [15:0] REG_BASE    = 16'hD000,
    parameter logic [15:0] VECTOR_BASE = 16'hFFE0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic [NUM_SRC-1:0] src,
    input  logic [15:0]        addr,
    input  logic [7:0]         din,
    input  logic               wr,
    input  logic               rd,
    input  logic               ack,
    output logic [7:0]         dout,
    output logic               irq_out,
    output logic [15:0]        vec_addr
);

    localparam logic [15:0] SPUR_VEC = VECTOR_BASE + 16'(2 * NUM_SRC);

    logic               rst_meta_q, rst_sync_q;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] isr_q, isr_d;
    logic [15:0]        vec_q, vec_d;

    logic               sel, wr_en, ack_take;
    logic [NUM_SRC-1:0] wdata, rise, elig, win_oh, pend_clr, eoi;
    logic [2:0]         win_id, cur_id;
    logic               cur_valid, blocked, found, cur_found;

    // Assert immediately, release two clk edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign sel      = (addr[15:3] == REG_BASE[15:3]);
    assign wr_en    = ce & wr & sel;
    assign wdata    = din[NUM_SRC-1:0];
    assign rise     = sync2_q & ~prev_q;
    assign ack_take = ack & irq_out;

    // A set ISR bit blocks its own index and every lower-priority one.
    always_comb begin
        blocked = 1'b0;
        elig    = '0;
        found   = 1'b0;
        win_id  = '0;
        win_oh  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            blocked = blocked | isr_q[i];
            elig[i] = pend_q[i] & mask_q[i] & ~blocked;
            if (elig[i] && !found) begin
                found     = 1'b1;
                win_id    = 3'(i);
                win_oh[i] = 1'b1;
            end
        end
    end

    assign irq_out = |elig;

    always_comb begin
        cur_found = 1'b0;
        cur_id    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (isr_q[i] && !cur_found) begin
                cur_found = 1'b1;
                cur_id    = 3'(i);
            end
        end
        cur_valid = |isr_q;
    end

    always_comb begin
        pend_clr = (wr_en && addr[2:0] == 3'd0) ? wdata : '0;
        eoi      = (wr_en && addr[2:0] == 3'd3) ? wdata : '0;
        if (ack_take) begin
            pend_clr = pend_clr | win_oh;
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pend_d[i] = mode_q[i] ? (rise[i] | (pend_q[i] & ~pend_clr[i])) : sync2_q[i];
        end
        mask_d = (wr_en && addr[2:0] == 3'd1) ? wdata : mask_q;
        mode_d = (wr_en && addr[2:0] == 3'd2) ? wdata : mode_q;
        isr_d  = (isr_q & ~eoi) | (ack_take ? win_oh : '0);
        vec_d  = vec_q;
        if (ack) begin
            vec_d = irq_out ? (VECTOR_BASE + {12'b0, win_id, 1'b0}) : SPUR_VEC;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            prev_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '1;
            isr_q  <= '0;
            vec_q  <= SPUR_VEC;
        end else if (ce) begin
            prev_q <= sync2_q;
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            isr_q  <= isr_d;
            vec_q  <= vec_d;
        end
    end

    assign vec_addr = vec_q;

    always_comb begin
        dout = '0;
        if (rd && sel) begin
            case (addr[2:0])
                3'd0:    dout = 8'(pend_q);
                3'd1:    dout = 8'(mask_q);
                3'd2:    dout = 8'(mode_q);
                3'd3:    dout = 8'(isr_q);
                3'd4:    dout = {cur_valid, 4'b0, cur_id};
                default: dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expected values.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic [7:0]  src;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        wr, rd, ack;
    logic [7:0]  dout;
    logic        irq_out;
    logic [15:0] vec_addr;

    int n_checks = 0;
    int n_fail   = 0;

    interrupt_controller #(
        .NUM_SRC    (8),
        .REG_BASE   (16'hD000),
        .VECTOR_BASE(16'hFFE0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .src     (src),
        .addr    (addr),
        .din     (din),
        .wr      (wr),
        .rd      (rd),
        .ack     (ack),
        .dout    (dout),
        .irq_out (irq_out),
        .vec_addr(vec_addr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] off, input logic [7:0] exp);
        logic [7:0] d;
        addr = 16'hD000 + {13'b0, off};
        rd   = 1'b1;
        #1;
        d    = dout;
        rd   = 1'b0;
        addr = 16'h0000;
        check(tag, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [7:0] data);
        addr = 16'hD000 + {13'b0, off};
        din  = data;
        wr   = 1'b1;
        tick(1);
        wr   = 1'b0;
        addr = 16'h0000;
        din  = 8'h00;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        src     = 8'h00;
        addr    = 16'h0000;
        din     = 8'h00;
        wr      = 1'b0;
        rd      = 1'b0;
        ack     = 1'b0;
        @(negedge clk);
        tick(3);
        check("rst_irq", {15'b0, irq_out}, 16'h0000);
        check("rst_vec", vec_addr, 16'hFFF0);
        chk_reg("rst_pend", 3'd0, 8'h00);
        chk_reg("rst_mode", 3'd2, 8'hFF);
        reset_n = 1'b1;
        tick(3);

        // Basic edge request on source 0
        wr_reg(3'd1, 8'h01);
        chk_reg("mask_rb", 3'd1, 8'h01);
        src = 8'h01;
        tick(2);
        chk_reg("lat_pend_early", 3'd0, 8'h00);
        tick(1);
        chk_reg("s0_pend", 3'd0, 8'h01);
        check("s0_irq", {15'b0, irq_out}, 16'h0001);
        src = 8'h00;
        do_ack();
        check("s0_vec", vec_addr, 16'hFFE0);
        chk_reg("s0_isr", 3'd3, 8'h01);
        chk_reg("s0_cur", 3'd4, 8'h80);
        chk_reg("s0_pend_clr", 3'd0, 8'h00);
        check("s0_irq_low", {15'b0, irq_out}, 16'h0000);

        // Spurious ack leaves ISR/CUR alone
        do_ack();
        check("spur_vec", vec_addr, 16'hFFF0);
        chk_reg("spur_isr", 3'd3, 8'h01);
        chk_reg("spur_cur", 3'd4, 8'h80);
        wr_reg(3'd3, 8'h01);
        chk_reg("eoi0_cur", 3'd4, 8'h00);

        // Priority and nesting
        wr_reg(3'd1, 8'hFF);
        src = 8'h24;
        tick(3);
        src = 8'h00;
        chk_reg("pri_pend", 3'd0, 8'h24);
        do_ack();
        check("pri_vec2", vec_addr, 16'hFFE4);
        chk_reg("pri_isr", 3'd3, 8'h04);
        check("pri_blk5", {15'b0, irq_out}, 16'h0000);
        src = 8'h02;
        tick(3);
        src = 8'h00;
        check("nest_irq", {15'b0, irq_out}, 16'h0001);
        do_ack();
        check("nest_vec1", vec_addr, 16'hFFE2);
        chk_reg("nest_cur", 3'd4, 8'h81);
        check("nest_blk5", {15'b0, irq_out}, 16'h0000);
        wr_reg(3'd3, 8'h06);
        check("eoi_irq", {15'b0, irq_out}, 16'h0001);
        do_ack();
        check("eoi_vec5", vec_addr, 16'hFFEA);
        chk_reg("eoi_cur", 3'd4, 8'h85);
        wr_reg(3'd3, 8'h20);
        chk_reg("eoi_isr0", 3'd3, 8'h00);

        // New edge coinciding with PEND write-clear: set wins
        src = 8'h10;
        tick(2);
        wr_reg(3'd0, 8'h10);
        chk_reg("setwin_pend", 3'd0, 8'h10);
        wr_reg(3'd0, 8'h10);
        chk_reg("wclr_pend", 3'd0, 8'h00);
        src = 8'h00;
        tick(3);

        // Level mode
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd1, 8'h08);
        src = 8'h08;
        tick(3);
        chk_reg("lvl_pend", 3'd0, 8'h08);
        tick(4);
        check("lvl_irq", {15'b0, irq_out}, 16'h0001);
        wr_reg(3'd0, 8'h08);
        chk_reg("lvl_wclr", 3'd0, 8'h08);
        do_ack();
        check("lvl_vec", vec_addr, 16'hFFE6);
        chk_reg("lvl_pend_ack", 3'd0, 8'h08);
        src = 8'h00;
        tick(2);
        chk_reg("lvl_drop_early", 3'd0, 8'h08);
        tick(1);
        chk_reg("lvl_drop", 3'd0, 8'h00);
        wr_reg(3'd3, 8'h08);
        wr_reg(3'd2, 8'hFF);
        wr_reg(3'd1, 8'hFF);

        // ce=0 gap: state frozen, edge caught when ce returns
        ce = 1'b0;
        tick(2);
        src = 8'h40;
        wr_reg(3'd1, 8'h00);
        tick(7);
        chk_reg("ce_pend", 3'd0, 8'h00);
        chk_reg("ce_mask", 3'd1, 8'hFF);
        check("ce_irq", {15'b0, irq_out}, 16'h0000);
        ce = 1'b1;
        tick(1);
        chk_reg("ce_pend6", 3'd0, 8'h40);
        check("ce_irq6", {15'b0, irq_out}, 16'h0001);
        do_ack();
        check("ce_vec6", vec_addr, 16'hFFEC);
        addr = 16'hD000;
        #1;
        check("rd_low", {8'h00, dout}, 16'h0000);
        addr = 16'h0000;
        chk_reg("off5", 3'd5, 8'h00);

        // Reset mid-service
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_irq", {15'b0, irq_out}, 16'h0000);
        check("mrst_vec", vec_addr, 16'hFFF0);
        chk_reg("mrst_isr", 3'd3, 8'h00);
        chk_reg("mrst_cur", 3'd4, 8'h00);
        chk_reg("mrst_mask", 3'd1, 8'h00);
        src = 8'h00;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
